alu_sequencer: RTL and testbench

//  Sequences the 8-bit ALU for the CPU core. Accepts one operation per request (valid/ready),

---
 rtl/alu_pkg.sv | 44 ++++
 rtl/bcd_fix.sv | 28 ++
 rtl/alu_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings, widths and payload types for the ALU sequencer.
//   op_e         - ALU operation codes (also driven on the ALU ctrl port)
//   seq_state_e  - sequencer FSM states
//   req_t        - latched request payload
//   BCD_*        - decimal-correction constants
package alu_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned OP_W   = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 4'd0,
        OP_OR  = 4'd1,
        OP_XOR = 4'd2,
        OP_AND = 4'd3,
        OP_SR  = 4'd4
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_ADJ  = 2'd2,
        S_DONE = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              ci;
        logic              dec;
    } req_t;

    localparam logic [DATA_W-1:0] BCD_LO_FIX = 8'h06;
    localparam logic [DATA_W-1:0] BCD_HI_FIX = 8'h60;
    localparam logic [3:0]        BCD_LO_MAX = 4'd9;
    localparam logic [DATA_W-1:0] BCD_HI_MAX = 8'h99;

    // Codes above OP_SR are reserved and reported as errors.
    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return op <= OP_W'(OP_SR);
    endfunction

endpackage

// File: rtl/bcd_fix.sv
// bcd_fix: decimal-correction term for a packed-BCD add, from the binary result.
//   i_sum     in  8  binary sum from the ALU
//   i_co_bin  in  1  binary carry out
//   i_hc      in  1  half carry out of the low nibble
//   o_fix_c   out 8  correction byte to add (0x00/0x06/0x60/0x66), combinational
//   o_carry_c out 1  decimal carry out, combinational
module bcd_fix
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] i_sum,
    input  logic              i_co_bin,
    input  logic              i_hc,
    output logic [DATA_W-1:0] o_fix_c,
    output logic              o_carry_c
);

    logic w_lo_fix;
    logic w_hi_fix;

    // A nibble needs +6 if it overflowed in binary or left the 0..9 range.
    always_comb begin
        w_lo_fix  = i_hc || (i_sum[3:0] > BCD_LO_MAX);
        w_hi_fix  = i_co_bin || (i_sum > BCD_HI_MAX);
        o_fix_c   = (w_lo_fix ? BCD_LO_FIX : '0) | (w_hi_fix ? BCD_HI_FIX : '0);
        o_carry_c = w_hi_fix;
    end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts one ALU operation per request, drives the external
// binary ALU (plus a second pass for decimal ADD), and holds the registered
// result and N/V/Z/C flags until the consumer takes it.
//   i_clk, i_rst                    clock, async active-high reset
//   i_req_valid / o_req_ready       request handshake (ready only in IDLE)
//   i_req_op/_a/_b/_ci/_dec         operation, operands, carry in, decimal mode
//   o_alu_ctrl/_ai/_bi/_ci/_d       ALU drive (alu_d always 0)
//   i_alu_out, i_alu_co             ALU result and carry out
//   o_rsp_valid / i_rsp_ready       response handshake
//   o_rsp_data/_n/_v/_z/_c/_err     result, flags, illegal-op indication
module alu_sequencer
    import alu_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [OP_W-1:0]   i_req_op,
    input  logic [DATA_W-1:0] i_req_a,
    input  logic [DATA_W-1:0] i_req_b,
    input  logic              i_req_ci,
    input  logic              i_req_dec,
    output logic [OP_W-1:0]   o_alu_ctrl,
    output logic [DATA_W-1:0] o_alu_ai,
    output logic [DATA_W-1:0] o_alu_bi,
    output logic              o_alu_ci,
    output logic              o_alu_d,
    input  logic [DATA_W-1:0] i_alu_out,
    input  logic              i_alu_co,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_rsp_n,
    output logic              o_rsp_v,
    output logic              o_rsp_z,
    output logic              o_rsp_c,
    output logic              o_rsp_err
);

    seq_state_e        r_state, w_state_nxt;
    req_t              r_req, w_req_nxt, w_req_in;
    logic              r_req_ready, w_req_ready_nxt;
    logic              r_rsp_valid, w_rsp_valid_nxt;
    logic [DATA_W-1:0] r_rsp_data, w_rsp_data_nxt;
    logic              r_rsp_n, w_rsp_n_nxt;
    logic              r_rsp_v, w_rsp_v_nxt;
    logic              r_rsp_z, w_rsp_z_nxt;
    logic              r_rsp_c, w_rsp_c_nxt;
    logic              r_rsp_err, w_rsp_err_nxt;
    logic [OP_W-1:0]   r_alu_ctrl, w_alu_ctrl_nxt;
    logic [DATA_W-1:0] r_alu_ai, w_alu_ai_nxt;
    logic [DATA_W-1:0] r_alu_bi, w_alu_bi_nxt;
    logic              r_alu_ci, w_alu_ci_nxt;

    logic              w_load_rsp;
    logic [4:0]        w_hc_sum;
    logic              w_hc;
    logic              w_add_v;
    logic [DATA_W-1:0] w_bcd_fix;
    logic              w_bcd_carry;

    // Incoming request payload
    always_comb begin
        w_req_in.op  = i_req_op;
        w_req_in.a   = i_req_a;
        w_req_in.b   = i_req_b;
        w_req_in.ci  = i_req_ci;
        w_req_in.dec = i_req_dec;
    end

    // Half carry and signed overflow of the binary add, from latched operands
    always_comb begin
        w_hc_sum = 5'({1'b0, r_req.a[3:0]}) + 5'({1'b0, r_req.b[3:0]}) + 5'(r_req.ci);
        w_hc     = w_hc_sum[4];
        w_add_v  = (r_req.a[7] == r_req.b[7]) && (i_alu_out[7] != r_req.a[7]);
    end

    // Correction is taken from the binary ALU result during EXEC
    bcd_fix u_bcd_fix (
        .i_sum     (i_alu_out),
        .i_co_bin  (i_alu_co),
        .i_hc      (w_hc),
        .o_fix_c   (w_bcd_fix),
        .o_carry_c (w_bcd_carry)
    );

    // Next state and next values of every registered output
    always_comb begin
        w_state_nxt     = r_state;
        w_req_nxt       = r_req;
        w_req_ready_nxt = r_req_ready;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_data_nxt  = r_rsp_data;
        w_rsp_n_nxt     = r_rsp_n;
        w_rsp_v_nxt     = r_rsp_v;
        w_rsp_z_nxt     = r_rsp_z;
        w_rsp_c_nxt     = r_rsp_c;
        w_rsp_err_nxt   = r_rsp_err;
        w_alu_ctrl_nxt  = r_alu_ctrl;
        w_alu_ai_nxt    = r_alu_ai;
        w_alu_bi_nxt    = r_alu_bi;
        w_alu_ci_nxt    = r_alu_ci;
        w_load_rsp      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_req_valid && r_req_ready) begin
                    w_req_nxt       = w_req_in;
                    w_req_ready_nxt = 1'b0;
                    w_state_nxt     = S_EXEC;
                    // ALU inputs are registered here so they are stable through EXEC
                    if (op_legal(i_req_op)) begin
                        w_alu_ctrl_nxt = i_req_op;
                        w_alu_ai_nxt   = i_req_a;
                        w_alu_bi_nxt   = i_req_b;
                        w_alu_ci_nxt   = i_req_ci;
                    end
                end
            end

            S_EXEC: begin
                w_load_rsp    = 1'b1;
                w_state_nxt   = S_DONE;
                w_rsp_v_nxt   = 1'b0;
                w_rsp_err_nxt = 1'b0;
                if (!op_legal(r_req.op)) begin
                    w_rsp_data_nxt = r_req.a;
                    w_rsp_c_nxt    = r_req.ci;
                    w_rsp_err_nxt  = 1'b1;
                end else begin
                    case (r_req.op)
                        OP_W'(OP_ADD): begin
                            w_rsp_v_nxt = w_add_v;
                            if (r_req.dec) begin
                                // Second pass adds the correction to the binary sum
                                w_load_rsp     = 1'b0;
                                w_state_nxt    = S_ADJ;
                                w_rsp_c_nxt    = w_bcd_carry;
                                w_alu_ctrl_nxt = OP_W'(OP_ADD);
                                w_alu_ai_nxt   = i_alu_out;
                                w_alu_bi_nxt   = w_bcd_fix;
                                w_alu_ci_nxt   = 1'b0;
                            end else begin
                                w_rsp_data_nxt = i_alu_out;
                                w_rsp_c_nxt    = i_alu_co;
                            end
                        end
                        OP_W'(OP_SR): begin
                            w_rsp_data_nxt = i_alu_out;
                            w_rsp_c_nxt    = r_req.a[0];
                        end
                        default: begin
                            w_rsp_data_nxt = i_alu_out;
                            w_rsp_c_nxt    = r_req.ci;
                        end
                    endcase
                end
            end

            S_ADJ: begin
                w_load_rsp     = 1'b1;
                w_state_nxt    = S_DONE;
                w_rsp_data_nxt = i_alu_out;
            end

            S_DONE: begin
                if (i_rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_req_ready_nxt = 1'b1;
                    w_state_nxt     = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // N/Z always follow the final result byte
        if (w_load_rsp) begin
            w_rsp_valid_nxt = 1'b1;
            w_rsp_n_nxt     = w_rsp_data_nxt[DATA_W-1];
            w_rsp_z_nxt     = (w_rsp_data_nxt == '0);
        end
    end

    // State and output registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_req       <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_n     <= 1'b0;
            r_rsp_v     <= 1'b0;
            r_rsp_z     <= 1'b0;
            r_rsp_c     <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_alu_ctrl  <= OP_W'(OP_ADD);
            r_alu_ai    <= '0;
            r_alu_bi    <= '0;
            r_alu_ci    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_req       <= w_req_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_rsp_n     <= w_rsp_n_nxt;
            r_rsp_v     <= w_rsp_v_nxt;
            r_rsp_z     <= w_rsp_z_nxt;
            r_rsp_c     <= w_rsp_c_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_alu_ctrl  <= w_alu_ctrl_nxt;
            r_alu_ai    <= w_alu_ai_nxt;
            r_alu_bi    <= w_alu_bi_nxt;
            r_alu_ci    <= w_alu_ci_nxt;
        end
    end

    assign o_req_ready = r_req_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_n     = r_rsp_n;
    assign o_rsp_v     = r_rsp_v;
    assign o_rsp_z     = r_rsp_z;
    assign o_rsp_c     = r_rsp_c;
    assign o_rsp_err   = r_rsp_err;
    assign o_alu_ctrl  = r_alu_ctrl;
    assign o_alu_ai    = r_alu_ai;
    assign o_alu_bi    = r_alu_bi;
    assign o_alu_ci    = r_alu_ci;
    // BCD correction is done here, so the ALU always runs in binary mode
    assign o_alu_d     = 1'b0;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural model of the external binary ALU.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_op;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic       req_ci;
    logic       req_dec;
    logic [3:0] alu_ctrl;
    logic [7:0] alu_ai;
    logic [7:0] alu_bi;
    logic       alu_ci;
    logic       alu_d;
    logic [7:0] alu_out;
    logic       alu_co;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_n, rsp_v, rsp_z, rsp_c, rsp_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_op    (req_op),
        .i_req_a     (req_a),
        .i_req_b     (req_b),
        .i_req_ci    (req_ci),
        .i_req_dec   (req_dec),
        .o_alu_ctrl  (alu_ctrl),
        .o_alu_ai    (alu_ai),
        .o_alu_bi    (alu_bi),
        .o_alu_ci    (alu_ci),
        .o_alu_d     (alu_d),
        .i_alu_out   (alu_out),
        .i_alu_co    (alu_co),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_data  (rsp_data),
        .o_rsp_n     (rsp_n),
        .o_rsp_v     (rsp_v),
        .o_rsp_z     (rsp_z),
        .o_rsp_c     (rsp_c),
        .o_rsp_err   (rsp_err)
    );

    // External binary ALU
    logic [8:0] sum9;
    always_comb begin
        sum9    = 9'({1'b0, alu_ai}) + 9'({1'b0, alu_bi}) + 9'(alu_ci);
        alu_out = 8'h00;
        alu_co  = 1'b0;
        case (alu_ctrl)
            4'd0: {alu_co, alu_out} = sum9;
            4'd1: alu_out = alu_ai | alu_bi;
            4'd2: alu_out = alu_ai ^ alu_bi;
            4'd3: alu_out = alu_ai & alu_bi;
            4'd4: begin
                alu_out = {1'b0, alu_ai[7:1]};
                alu_co  = alu_ai[0];
            end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // flags order: {n, v, z, c, err}
    task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic ci, input logic dec,
                          input int exp_lat, input logic [7:0] exp_data, input logic [4:0] exp_flags);
        int lat;
        @(negedge clk);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_ci    = ci;
        req_dec   = dec;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_data"}, 32'(rsp_data), 32'(exp_data));
        chk({tag, "_flags"}, 32'({rsp_n, rsp_v, rsp_z, rsp_c, rsp_err}), 32'(exp_flags));
        chk({tag, "_alu_d"}, 32'(alu_d), 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_ready_back"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 4'd0;
        req_a     = 8'h00;
        req_b     = 8'h00;
        req_ci    = 1'b0;
        req_dec   = 1'b0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_flags", 32'({rsp_n, rsp_v, rsp_z, rsp_c, rsp_err}), 32'd0);
        chk("rst_alu", 32'({alu_ctrl, alu_ai, alu_bi, alu_ci, alu_d}), 32'd0);

        // Binary and logic operations
        run_op("add_ovf",   4'd0, 8'h7F, 8'h01, 1'b0, 1'b0, 2, 8'h80, 5'b11000);
        run_op("add_wrap",  4'd0, 8'hFF, 8'h01, 1'b0, 1'b0, 2, 8'h00, 5'b00110);
        run_op("sr",        4'd4, 8'h81, 8'h00, 1'b0, 1'b0, 2, 8'h40, 5'b00010);
        run_op("or",        4'd1, 8'hF0, 8'h0F, 1'b1, 1'b0, 2, 8'hFF, 5'b10010);
        run_op("xor_zero",  4'd2, 8'h55, 8'h55, 1'b0, 1'b0, 2, 8'h00, 5'b00100);
        run_op("and",       4'd3, 8'hF0, 8'h3C, 1'b0, 1'b0, 2, 8'h30, 5'b00000);
        run_op("or_dec_ig", 4'd1, 8'h12, 8'h09, 1'b0, 1'b1, 2, 8'h1B, 5'b00000);
        run_op("illegal",   4'hA, 8'h3C, 8'h11, 1'b1, 1'b0, 2, 8'h3C, 5'b00011);

        // Decimal ADD
        run_op("dec_58_46", 4'd0, 8'h58, 8'h46, 1'b1, 1'b1, 3, 8'h05, 5'b01010);
        run_op("dec_09_01", 4'd0, 8'h09, 8'h01, 1'b0, 1'b1, 3, 8'h10, 5'b00000);
        run_op("dec_19_28", 4'd0, 8'h19, 8'h28, 1'b0, 1'b1, 3, 8'h47, 5'b00000);
        run_op("dec_99_01", 4'd0, 8'h99, 8'h01, 1'b0, 1'b1, 3, 8'h00, 5'b00110);

        // Back-pressure: response held, new requests ignored
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 4'd0;
        req_a     = 8'h7F;
        req_b     = 8'h01;
        req_ci    = 1'b0;
        req_dec   = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            req_op    = 4'd1;
            req_a     = 8'h00;
            req_b     = 8'h00;
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_data", 32'(rsp_data), 32'h80);
            chk("hold_flags", 32'({rsp_n, rsp_v, rsp_z, rsp_c, rsp_err}), 32'b11000);
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("hold_end_data", 32'(rsp_data), 32'h80);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("hold_release", 32'(rsp_valid), 32'd0);
        chk("hold_ready_back", 32'(req_ready), 32'd1);
        repeat (3) @(negedge clk);
        chk("hold_no_ghost", 32'(rsp_valid), 32'd0);

        // Reset during the decimal correction cycle
        req_valid = 1'b1;
        req_op    = 4'd0;
        req_a     = 8'h58;
        req_b     = 8'h46;
        req_ci    = 1'b1;
        req_dec   = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("adj_ai", 32'(alu_ai), 32'h9F);
        chk("adj_bi", 32'(alu_bi), 32'h66);
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_data", 32'(rsp_data), 32'd0);
        chk("midrst_alu", 32'({alu_ctrl, alu_ai, alu_bi, alu_ci, alu_d}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_ready", 32'(req_ready), 32'd1);
        chk("postrst_flags", 32'({rsp_n, rsp_v, rsp_z, rsp_c, rsp_err}), 32'd0);
        repeat (4) @(negedge clk);
        chk("postrst_no_rsp", 32'(rsp_valid), 32'd0);

        // Normal operation resumes after reset
        run_op("after_rst", 4'd0, 8'h01, 8'h02, 1'b1, 1'b0, 2, 8'h04, 5'b00000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
